// File: rtl/piso_pkg.sv
// Shared constants and helpers for the piso_8bit serializer.
package piso_pkg;

    localparam int PISO_WIDTH = 8;

    // Bits needed to count 0..w-1 frame positions.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Free-running frame position counter; frame_start flags position 0.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH
) (
    input  logic clk,
    input  logic reset,
    output logic frame_start
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_start = (cnt_q == '0);

endmodule

// File: rtl/piso_8bit.sv
// Continuous parallel-in serial-out shifter, back-to-back WIDTH-cycle frames.
// Define PISO_LSB_FIRST_EN to serialize LSB first instead of MSB first.
module piso_8bit
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             reset,
    output logic             q
);

    logic             frame_start;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             q_q;
    logic             q_d;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start)
    );

    // First bit goes straight to q; sr keeps the rest, pre-aligned to the exit end.
    always_comb begin
`ifdef PISO_LSB_FIRST_EN
        if (frame_start) begin
            q_d  = d[0];
            sr_d = {1'b0, d[WIDTH-1:1]};
        end else begin
            q_d  = sr_q[0];
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
`else
        if (frame_start) begin
            q_d  = d[WIDTH-1];
            sr_d = {d[WIDTH-2:0], 1'b0};
        end else begin
            q_d  = sr_q[WIDTH-1];
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
            q_q  <= 1'b0;
        end else begin
            sr_q <= sr_d;
            q_q  <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_piso_8bit.sv
// Directed bench for piso_8bit (8-bit and 4-bit instances, shared reset).
module tb_piso_8bit;

    logic       clk;
    logic       reset;
    logic [7:0] d8;
    logic [3:0] d4;
    logic       q8;
    logic       q4;

    int n_checks;
    int n_errors;

    // Expected serial order, index 7 (or 3) emitted first.
`ifdef PISO_LSB_FIRST_EN
    logic [7:0] exp_e9 = 8'b1001_0111;
    logic [7:0] exp_0f = 8'b1111_0000;
    logic [3:0] exp_a  = 4'b0101;
`else
    logic [7:0] exp_e9 = 8'b1110_1001;
    logic [7:0] exp_0f = 8'b0000_1111;
    logic [3:0] exp_a  = 4'b1010;
`endif

    piso_8bit dut8 (
        .d    (d8),
        .clk  (clk),
        .reset(reset),
        .q    (q8)
    );

    piso_8bit #(
        .WIDTH(4)
    ) dut4 (
        .d    (d4),
        .clk  (clk),
        .reset(reset),
        .q    (q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        d8       = 8'hE9;
        d4       = 4'hA;

        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_q8_%0d", i), 32'(q8), 32'd0);
            check($sformatf("reset_q4_%0d", i), 32'(q4), 32'd0);
        end

        // Frame 1 (E9) with d changed mid-frame, then frame 2 (0F).
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k < 8) begin
                check($sformatf("frame1_bit%0d", k), 32'(q8), 32'(exp_e9[7-k]));
            end else begin
                check($sformatf("frame2_bit%0d", k - 8), 32'(q8), 32'(exp_0f[15-k]));
            end
            check($sformatf("w4_bit%0d", k), 32'(q4), 32'(exp_a[3-(k%4)]));
            if (k == 0) d8 = 8'h0F;
        end

        // Partial frame, then reset mid-frame.
        d8 = 8'hE9;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("partial_bit%0d", k), 32'(q8), 32'(exp_e9[7-k]));
        end
        reset = 1'b1;
        tick();
        check("midreset_q8", 32'(q8), 32'd0);
        check("midreset_q4", 32'(q4), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("restart_bit%0d", k), 32'(q8), 32'(exp_e9[7-k]));
            check($sformatf("restart_w4_bit%0d", k), 32'(q4), 32'(exp_a[3-(k%4)]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/piso_8bit.md
PISO_8BIT -- requirements
Module: piso_8bit

Interface
REQ-001 Parameter: WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock; all state changes occur only on this edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: d  input  WIDTH  parallel data word; sampled only at frame start.
REQ-005 Port: q  output  1  registered serial data bit.
REQ-006 The module SHALL declare its ports in the positional order d, clk, reset, q, so that existing positional instantiations connect correctly.

Function
REQ-007 The module SHALL run continuous back-to-back frames of WIDTH cycles each, with no idle cycles and no handshake.
REQ-008 The module SHALL hold a WIDTH-bit shift register sr and a bit counter cnt (0..WIDTH-1), both internal.
REQ-009 On an edge with cnt==0 and reset low, the module SHALL: sample d, drive q to the first bit (d[WIDTH-1] by default), and load sr with the remaining bits.
REQ-010 On an edge with cnt!=0 and reset low, the module SHALL drive q to the next bit from sr and shift sr by one position.
REQ-011 The module SHALL wrap cnt from WIDTH-1 to 0, so the next frame reloads d on the following edge.
REQ-012 Output latency: bit k (k=0..WIDTH-1) of a frame SHALL appear on q after the (k+1)-th rising edge of that frame.
REQ-013 Changes on d during a frame (cnt!=0) SHALL NOT affect the frame in progress.
REQ-014 The default order SHALL be MSB first: the sequence for frame word D is D[WIDTH-1], D[WIDTH-2], ..., D[0].
REQ-015 q SHALL be driven directly from a flop, with no combinational path from d or reset to q.

Reset
REQ-016 While reset=1 at a rising edge, the module SHALL set q=0, sr=0 and cnt=0.
REQ-017 If reset is asserted mid-frame, the module SHALL abandon the partial frame; no bits of it are emitted after reset.
REQ-018 The first edge with reset=0 SHALL be a frame start (REQ-009).
REQ-019 Before the first reset edge, q is undefined; no power-up value is required.

Configuration
REQ-020 Macro PISO_LSB_FIRST_EN, if defined, SHALL select LSB-first order: D[0], D[1], ..., D[WIDTH-1].
REQ-021 If PISO_LSB_FIRST_EN is not defined, the module SHALL use MSB-first order.
REQ-022 Counter, reset and latency behaviour SHALL be identical in both build variants.

Structure
REQ-023 Shared package piso_pkg SHALL hold: the default-width constant PISO_WIDTH=8 and the counter-width function (clog2 of WIDTH).
REQ-024 The frame bit counter SHALL be a sub-module named piso_bit_counter, with inputs clk, reset and output frame_start (cnt==0).
REQ-025 The shift register and the q flop SHALL reside in piso_8bit.

Verification
REQ-026 Reset: hold reset=1 for 3 edges with d=8'hE9 -> q=0 after each edge.
REQ-027 MSB-first: d=8'hE9, release reset -> q over 8 edges = 1,1,1,0,1,0,0,1.
REQ-028 Wrap and reload:
- d=8'hE9 for the first frame, change d to 8'h0F during bits 1..7 of that frame -> first frame is unchanged.
- Second frame = 0,0,0,0,1,1,1,1.
REQ-029 Mid-frame reset: assert reset after bit 3 of 8'hE9 -> q=0 on the next edge; after release, the frame restarts from d[7].
REQ-030 PISO_LSB_FIRST_EN defined, d=8'hE9 -> q = 1,0,0,1,0,1,1,1.
REQ-031 WIDTH=4, d=4'hA -> repeating 1,0,1,0 with a 4-edge period.
